usb_reg_cmd_ctrl: RTL and testbench
===================================

# usb_reg_cmd_ctrl

Command engine on the USB3 (FT601Q 245-FIFO) data path, on the user side of the FT601Q wrapper's FIFOs. Pops 32-bit command packets from the wrapper's RX FIFO and turns them into register-bus writes and reads. For read commands it pushes a response packet into the wrapper's TX FIFO. Gives the host a simple memory-mapped control channel over USB3.

## Interface
Parameters:
- ADDR_W, 16: register address width (at most 32).
- MAX_LEN, 256: largest legal burst length, in words.
- RD_TIMEOUT, 1024: cycles to wait for reg_rvalid before a read is substituted.

Ports:
- sys_clk_i  in  1  single clock; the wrapper's rx_clk/tx_clk are tied to it.
- rst_i  in  1  asynchronous, active-high reset.
- rx_dout  in  32  RX FIFO data, first-word-fall-through: valid whenever rx_empty=0.
- rx_empty  in  1  RX FIFO empty.
- rx_en  out  1  RX pop; the word on rx_dout is consumed in the same cycle.
- tx_din  out  32  TX FIFO write data.
- tx_en  out  1  TX FIFO write strobe.
- tx_prog_full  in  1  TX FIFO almost full; at least 2 words of headroom remain.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  32  register write data.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rdata  in  32  read data, qualified by reg_rvalid.
- reg_rvalid  in  1  read data valid; arrives 1 or more cycles after reg_rd_en.
- cmd_busy  out  1  high in every state except IDLE.
- err_cnt  out  16  saturating count of protocol errors and read timeouts.

## Operation
- Packet layout:
  - Word 0 (header): [31:24]=8'hA5 sync, [23:16]=opcode (8'h01 write, 8'h02 read), [15:0]=LEN.
  - Word 1: start address; bits [ADDR_W-1:0] are used.
  - Write packets then carry LEN data words.
- Header is legal only when sync=A5, the opcode is 01 or 02, and 1 ≤ LEN ≤ MAX_LEN.
  - Illegal header: the word is popped and dropped, err_cnt increments, state stays IDLE.
  - This resynchronises the parser on garbage.
- States: IDLE, ADDR, WR_DATA, RSP_HDR, RD_REQ, RD_WAIT, RD_SEND.
  - IDLE → ADDR: legal header popped. Opcode and LEN are latched.
  - ADDR → WR_DATA (write) or RSP_HDR (read): address word popped. The address is latched into reg_addr.
  - WR_DATA: each popped word drives reg_wdata and a reg_wr_en pulse. The address increments after each write. Return to IDLE after LEN writes.
  - RSP_HDR: push {8'h5A, 8'h02, LEN} when tx_prog_full=0, then go to RD_REQ.
  - RD_REQ: pulse reg_rd_en, then go to RD_WAIT.
  - RD_WAIT: on reg_rvalid, capture reg_rdata and go to RD_SEND. If RD_TIMEOUT cycles pass with no reg_rvalid, capture 32'hDEAD_BEEF, increment err_cnt, and go to RD_SEND.
  - RD_SEND: push the captured word when tx_prog_full=0 and increment the address. Go back to RD_REQ, or to IDLE after LEN words.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- err_cnt saturates at 16'hFFFF.
- Only one read is outstanding at a time.
- reg_rvalid outside RD_WAIT is ignored.

## Timing
- Reset values (async assert, sync deassert): every output 0; state IDLE; internal counters 0.
- rx_en is combinational: state ∈ {IDLE, ADDR, WR_DATA} and rx_empty=0. At most 1 pop per cycle.
- Write path: reg_wr_en, reg_wdata and reg_addr are registered and appear 1 cycle after the pop. Back-to-back words give back-to-back strobes, 1 write per cycle.
- An empty RX FIFO in the middle of a packet stalls the block indefinitely. There is no RX timeout.
- tx_en is registered and asserted only in a cycle where tx_prog_full was 0 on the preceding edge.
- Read sequence, with no stalls and reg_rvalid on the cycle after reg_rd_en:
  - the response header is written 1 cycle after the address pop;
  - each data word then takes 4 cycles: REQ, WAIT, rvalid, SEND.
- tx_prog_full stalls RSP_HDR and RD_SEND. Register reads are not re-issued during the stall.
- Reset mid-packet aborts the packet. Leftover FIFO words are later popped as illegal headers and counted in err_cnt.
- On the last word, returning to IDLE and accepting a new header happen on consecutive cycles, so there is no idle gap.

## Test plan
- Write burst: A5010003, 00000010, 11, 22, 33 → reg_wr_en on 3 consecutive cycles at addresses 0x10/0x11/0x12 with data 11/22/33; cmd_busy then 0; err_cnt=0.
- Read burst: A5020002, 0000FFFF; regs return 0xCAFE0000 and 0xCAFE0001 with latency 3 → TX gets 5A020002, CAFE0000, CAFE0001; the second read address is 0x0000 (wrap).
- Garbage then a valid command: 12345678, A5070001, A5010000, then a legal 1-word write → err_cnt=3 and the write executes.
- Read timeout: A5020001, addr 0x4, reg_rvalid never asserted → after RD_TIMEOUT cycles TX gets 5A020001, DEADBEEF; err_cnt=1.
- Backpressure: hold tx_prog_full=1 during a 4-word read → no tx_en while it is high, no duplicated reg_rd_en, and all 5 response words are in order after release. Separately, empty RX mid-write → writes pause and resume with correct addresses.
- Reset asserted mid-write burst → outputs 0 immediately; after release, the stale data word is popped as an illegal header and err_cnt=1.

Source files
------------

// File: rtl/usb_reg_cmd_ctrl.sv
// Command engine behind the FT601Q 245-FIFO wrapper: turns host packets popped from the
// RX FIFO into register-bus writes/reads and returns read responses through the TX FIFO.
module usb_reg_cmd_ctrl #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MAX_LEN    = 256,
    parameter int unsigned RD_TIMEOUT = 1024
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic [31:0]       rx_dout,
    input  logic              rx_empty,
    output logic              rx_en,
    output logic [31:0]       tx_din,
    output logic              tx_en,
    input  logic              tx_prog_full,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_rvalid,
    output logic              cmd_busy,
    output logic [15:0]       err_cnt
);

    localparam int unsigned TMO_W = $clog2(RD_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
    localparam logic [7:0]  SYNC_CMD  = 8'hA5;
    localparam logic [7:0]  SYNC_RSP  = 8'h5A;
    localparam logic [7:0]  OP_WR     = 8'h01;
    localparam logic [7:0]  OP_RD     = 8'h02;
    localparam logic [31:0] RD_FILLER = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_DATA,
        RSP_HDR,
        RD_REQ,
        RD_WAIT,
        RD_SEND
    } state_t;

    state_t            state;
    logic              op_rd;
    logic [15:0]       len;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       rd_word;
    logic [TMO_W-1:0]  tmo;
    logic              hdr_ok;
    logic              last_word;
    logic              err_sat;

    // Pop is combinational so the FIFO word is consumed in the cycle the FSM uses it
    assign rx_en = !rst_i && !rx_empty &&
                   ((state == IDLE) || (state == ADDR) || (state == WR_DATA));

    assign hdr_ok = (rx_dout[31:24] == SYNC_CMD) &&
                    ((rx_dout[23:16] == OP_WR) || (rx_dout[23:16] == OP_RD)) &&
                    (rx_dout[15:0] != 16'd0) &&
                    (32'(rx_dout[15:0]) <= MAX_LEN);

    assign last_word = (cnt == (len - 16'd1));
    assign err_sat   = (err_cnt == 16'hFFFF);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            op_rd     <= 1'b0;
            len       <= '0;
            cnt       <= '0;
            cur_addr  <= '0;
            rd_word   <= '0;
            tmo       <= '0;
            tx_din    <= '0;
            tx_en     <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            cmd_busy  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            tx_en     <= 1'b0;

            case (state)
                // Illegal headers are dropped one word at a time to resync on garbage
                IDLE: begin
                    if (rx_en) begin
                        if (hdr_ok) begin
                            op_rd    <= (rx_dout[23:16] == OP_RD);
                            len      <= rx_dout[15:0];
                            cnt      <= '0;
                            cmd_busy <= 1'b1;
                            state    <= ADDR;
                        end else if (!err_sat) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                    end
                end

                ADDR: begin
                    if (rx_en) begin
                        cur_addr <= rx_dout[ADDR_W-1:0];
                        reg_addr <= rx_dout[ADDR_W-1:0];
                        state    <= op_rd ? RSP_HDR : WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (rx_en) begin
                        reg_wdata <= rx_dout;
                        reg_wr_en <= 1'b1;
                        reg_addr  <= cur_addr;
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        cnt       <= cnt + 16'd1;
                        if (last_word) begin
                            cmd_busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end

                RSP_HDR: begin
                    if (!tx_prog_full) begin
                        tx_en  <= 1'b1;
                        tx_din <= {SYNC_RSP, OP_RD, len};
                        state  <= RD_REQ;
                    end
                end

                RD_REQ: begin
                    reg_rd_en <= 1'b1;
                    reg_addr  <= cur_addr;
                    tmo       <= '0;
                    state     <= RD_WAIT;
                end

                // A missing response is replaced by a filler word so the host still gets LEN words
                RD_WAIT: begin
                    if (reg_rvalid) begin
                        rd_word <= reg_rdata;
                        state   <= RD_SEND;
                    end else if (tmo == TMO_LAST) begin
                        rd_word <= RD_FILLER;
                        if (!err_sat) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                        state <= RD_SEND;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end

                RD_SEND: begin
                    if (!tx_prog_full) begin
                        tx_en    <= 1'b1;
                        tx_din   <= rd_word;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        cnt      <= cnt + 16'd1;
                        if (last_word) begin
                            cmd_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end

                default: begin
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_reg_cmd_ctrl.sv
// Bench for usb_reg_cmd_ctrl: FIFO and register-bus models around the DUT, with a
// packet-level reference model predicting writes, TX words and err_cnt.
module tb_usb_reg_cmd_ctrl;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned MAX_LEN    = 256;
    localparam int unsigned RD_TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       rx_dout;
    logic              rx_empty;
    logic              rx_en;
    logic [31:0]       tx_din;
    logic              tx_en;
    logic              tx_prog_full;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [31:0]       reg_rdata;
    logic              reg_rvalid;
    logic              cmd_busy;
    logic [15:0]       err_cnt;

    usb_reg_cmd_ctrl #(
        .ADDR_W    (ADDR_W),
        .MAX_LEN   (MAX_LEN),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .sys_clk_i   (clk),
        .rst_i       (rst),
        .rx_dout     (rx_dout),
        .rx_empty    (rx_empty),
        .rx_en       (rx_en),
        .tx_din      (tx_din),
        .tx_en       (tx_en),
        .tx_prog_full(tx_prog_full),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .cmd_busy    (cmd_busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] rx_q[$];
    logic [31:0] cmd_q[$];
    logic [31:0] tx_got[$];
    logic [31:0] exp_tx[$];
    logic [47:0] wr_got[$];
    logic [47:0] exp_wr[$];
    int          wr_cyc[$];
    int          exp_err = 0;
    logic        rx_hold = 1'b0;
    logic        chaos = 1'b0;
    logic        rsp_enable = 1'b1;
    int          lat = 1;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          rd_cyc = 0;
    int          tx_cyc = 0;
    int          pf_viol = 0;
    logic        rsp_pend = 1'b0;
    int          rsp_cnt = 0;
    logic [15:0] rsp_addr = '0;

    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        logic [15:0] t;
        t = a + 16'd1;
        return 32'hCAFE_0000 + {16'h0, t};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // RX FIFO model: first-word-fall-through, popped when the DUT's pre-edge rx_en was high
    always @(posedge clk) begin
        automatic logic p = rx_en;
        #1;
        if (p && rx_q.size() != 0) void'(rx_q.pop_front());
        rx_empty = rx_hold || (rx_q.size() == 0);
        rx_dout  = (rx_q.size() != 0) ? rx_q[0] : 32'h0;
    end

    // Output monitor and register-bus responder
    always @(posedge clk) begin
        #2;
        cyc++;
        if (tx_en) begin
            tx_got.push_back(tx_din);
            tx_cyc = cyc;
            if (tx_prog_full) pf_viol++;
        end
        if (reg_wr_en) begin
            wr_got.push_back({reg_addr, reg_wdata});
            wr_cyc.push_back(cyc);
        end
        reg_rvalid = 1'b0;
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                reg_rvalid = 1'b1;
                reg_rdata  = rd_fn(rsp_addr);
                rsp_pend   = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        if (reg_rd_en) begin
            rd_cnt++;
            rd_cyc = cyc;
            if (rsp_enable) begin
                rsp_pend = 1'b1;
                rsp_cnt  = (chaos ? $urandom_range(1, 4) : lat) - 1;
                rsp_addr = reg_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (chaos) begin
            rx_hold      = ($urandom_range(0, 3) == 0);
            tx_prog_full = ($urandom_range(0, 3) == 0);
        end
    end

    // Packet-level reference: walks the word stream as the host protocol defines it
    task automatic model();
        int i;
        logic [31:0] h;
        logic [15:0] n;
        logic [15:0] a;
        i = 0;
        while (i < cmd_q.size()) begin
            h = cmd_q[i];
            i++;
            n = h[15:0];
            if (h[31:24] != 8'hA5 || !(h[23:16] == 8'h01 || h[23:16] == 8'h02) ||
                n == 16'd0 || 32'(n) > MAX_LEN) begin
                exp_err++;
                continue;
            end
            if (i >= cmd_q.size()) break;
            a = cmd_q[i][15:0];
            i++;
            if (h[23:16] == 8'h01) begin
                for (int k = 0; k < int'(n) && i < cmd_q.size(); k++) begin
                    exp_wr.push_back({a + 16'(k), cmd_q[i]});
                    i++;
                end
            end else begin
                exp_tx.push_back({8'h5A, 8'h02, n});
                for (int k = 0; k < int'(n); k++) begin
                    if (rsp_enable) exp_tx.push_back(rd_fn(a + 16'(k)));
                    else begin
                        exp_tx.push_back(32'hDEAD_BEEF);
                        exp_err++;
                    end
                end
            end
        end
    endtask

    task automatic launch();
        model();
        foreach (cmd_q[i]) rx_q.push_back(cmd_q[i]);
        cmd_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < budget && !(rx_q.size() == 0 && !cmd_busy));
        chk({tag, " idle_timeout"}, 64'(n >= budget), 64'(0));
    endtask

    task automatic wait_wr(input string tag, input int count);
        int n;
        n = 0;
        while (n < 200 && wr_got.size() < count) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " wr_wait_timeout"}, 64'(n >= 200), 64'(0));
    endtask

    task automatic compare_all(input string tag);
        chk({tag, " wr_count"}, 64'(wr_got.size()), 64'(exp_wr.size()));
        for (int i = 0; i < wr_got.size() && i < exp_wr.size(); i++)
            chk({tag, " wr"}, 64'(wr_got[i]), 64'(exp_wr[i]));
        chk({tag, " tx_count"}, 64'(tx_got.size()), 64'(exp_tx.size()));
        for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++)
            chk({tag, " tx"}, 64'(tx_got[i]), 64'(exp_tx[i]));
        chk({tag, " err_cnt"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, " tx_while_full"}, 64'(pf_viol), 64'(0));
        chk({tag, " busy"}, 64'(cmd_busy), 64'(0));
        wr_got.delete();
        exp_wr.delete();
        tx_got.delete();
        exp_tx.delete();
        wr_cyc.delete();
    endtask

    function automatic logic [31:0] garbage();
        logic [31:0] g;
        g = $urandom;
        case ($urandom_range(0, 3))
            0: if (g[31:24] == 8'hA5) g[31:24] = 8'h00;
            1: g = {8'hA5, 8'h03 + 8'($urandom_range(0, 250)), 16'd1};
            2: g = {8'hA5, 8'h01, 16'd0};
            default: g = {8'hA5, 8'h02, 16'($urandom_range(MAX_LEN + 1, 65535))};
        endcase
        return g;
    endfunction

    initial begin
        int n;
        logic [31:0] w;
        rst          = 1'b1;
        tx_prog_full = 1'b0;
        reg_rvalid   = 1'b0;
        reg_rdata    = '0;
        rx_empty     = 1'b1;
        rx_dout      = '0;
        repeat (3) @(negedge clk);
        chk("rst tx_en", 64'(tx_en), 64'(0));
        chk("rst reg_wr_en", 64'(reg_wr_en), 64'(0));
        chk("rst reg_rd_en", 64'(reg_rd_en), 64'(0));
        chk("rst cmd_busy", 64'(cmd_busy), 64'(0));
        chk("rst err_cnt", 64'(err_cnt), 64'(0));
        chk("rst reg_addr", 64'(reg_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Write burst, back-to-back strobes
        cmd_q = '{32'hA501_0003, 32'h0000_0010, 32'h11, 32'h22, 32'h33};
        launch();
        wait_idle("wr_burst", 100);
        chk("wr_burst strobe_span", 64'(wr_cyc.size() == 3 ? wr_cyc[2] - wr_cyc[0] : -1), 64'(2));
        compare_all("wr_burst");

        // Read burst with address wrap, latency 3
        lat = 3;
        cmd_q = '{32'hA502_0002, 32'h0000_FFFF};
        launch();
        wait_idle("rd_wrap", 200);
        chk("rd_wrap last_word", 64'(tx_got.size() == 3 ? tx_got[2] : 32'h0), 64'(32'hCAFE_0001));
        compare_all("rd_wrap");

        // Garbage headers then a legal write
        cmd_q = '{32'h1234_5678, 32'hA507_0001, 32'hA501_0000,
                  32'hA501_0001, 32'h0000_0040, 32'h0BAD_F00D};
        launch();
        wait_idle("garbage", 100);
        compare_all("garbage");

        // Read timeout
        rsp_enable = 1'b0;
        cmd_q = '{32'hA502_0001, 32'h0000_0004};
        launch();
        wait_idle("timeout", 3 * RD_TIMEOUT);
        n = tx_cyc - rd_cyc;
        chk("timeout delay_in_range", 64'(n >= int'(RD_TIMEOUT) && n <= int'(RD_TIMEOUT) + 2), 64'(1));
        compare_all("timeout");
        rsp_enable = 1'b1;

        // TX backpressure during a 4-word read
        lat = 1;
        rd_cnt = 0;
        tx_prog_full = 1'b1;
        cmd_q = '{32'hA502_0004, 32'h0000_0100};
        launch();
        repeat (20) @(negedge clk);
        chk("bp hdr_held", 64'(tx_got.size()), 64'(0));
        chk("bp no_read_before_hdr", 64'(rd_cnt), 64'(0));
        tx_prog_full = 1'b0;
        n = 0;
        while (n < 100 && tx_got.size() < 2) begin
            @(negedge clk);
            n++;
        end
        tx_prog_full = 1'b1;
        repeat (30) @(negedge clk);
        chk("bp send_held", 64'(tx_got.size()), 64'(2));
        chk("bp single_read", 64'(rd_cnt), 64'(2));
        tx_prog_full = 1'b0;
        wait_idle("bp", 200);
        chk("bp total_reads", 64'(rd_cnt), 64'(4));
        compare_all("bp");

        // RX underrun in the middle of a write burst
        cmd_q = '{32'hA501_0004, 32'h0000_0200, 32'hD0, 32'hD1, 32'hD2, 32'hD3};
        model();
        for (int i = 0; i < 4; i++) rx_q.push_back(cmd_q[i]);
        wait_wr("underrun", 2);
        repeat (10) @(negedge clk);
        chk("underrun paused", 64'(wr_got.size()), 64'(2));
        chk("underrun busy", 64'(cmd_busy), 64'(1));
        rx_q.push_back(cmd_q[4]);
        rx_q.push_back(cmd_q[5]);
        cmd_q.delete();
        wait_idle("underrun", 100);
        compare_all("underrun");

        // Randomized command streams with random RX gaps, TX backpressure and read latency
        chaos = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 4) == 0) begin
                    cmd_q.push_back(garbage());
                end else begin
                    n = $urandom_range(1, 8);
                    w = $urandom;
                    if ($urandom_range(0, 1) == 0) begin
                        cmd_q.push_back({8'hA5, 8'h01, 16'(n)});
                        cmd_q.push_back(w);
                        for (int k = 0; k < n; k++) cmd_q.push_back($urandom);
                    end else begin
                        cmd_q.push_back({8'hA5, 8'h02, 16'(n)});
                        cmd_q.push_back(w);
                    end
                end
            end
            launch();
            wait_idle("random", 5000);
            compare_all("random");
        end
        chaos = 1'b0;
        @(negedge clk);
        rx_hold      = 1'b0;
        tx_prog_full = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write burst
        rx_q.push_back(32'hA501_0004);
        rx_q.push_back(32'h0000_0300);
        rx_q.push_back(32'h0000_AAAA);
        wait_wr("rst_mid", 1);
        rx_hold = 1'b1;
        rx_q.push_back(32'h0000_BBBB);
        repeat (3) @(negedge clk);
        chk("rst_mid first_write", 64'(wr_got.size() != 0 ? wr_got[0] : 48'h0), 64'({16'h0300, 32'h0000_AAAA}));
        wr_got.delete();
        wr_cyc.delete();
        rst = 1'b1;
        #1;
        chk("rst_mid reg_wr_en", 64'(reg_wr_en), 64'(0));
        chk("rst_mid reg_addr", 64'(reg_addr), 64'(0));
        chk("rst_mid reg_wdata", 64'(reg_wdata), 64'(0));
        chk("rst_mid cmd_busy", 64'(cmd_busy), 64'(0));
        chk("rst_mid err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_mid tx_din", 64'(tx_din), 64'(0));
        chk("rst_mid rx_en", 64'(rx_en), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        cmd_q = '{32'h0000_BBBB};
        model();
        cmd_q.delete();
        rx_hold = 1'b0;
        wait_idle("rst_mid", 100);
        compare_all("rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
